// File: rtl/divider_pkg.sv
// Shared definitions for the execute-stage integer divider.
// Holds the divider FSM state encoding, the execute-stage DIV/DIVU operator
// codes, the operand width and a conditional two's-complement negate helper.
package divider_pkg;

    // Divider control states (2-bit).
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Execute-stage operator codes; the execute stage decodes these to drive
    // signed_div and start.
    typedef enum logic [7:0] {
        EXE_OP_DIV  = 8'b0001_1010,
        EXE_OP_DIVU = 8'b0001_1011
    } exe_op_e;

    localparam int         DIV_WIDTH = 32;
    localparam logic [5:0] DIV_ITERS = 6'd32;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [DIV_WIDTH-1:0] cond_negate(
        input logic [DIV_WIDTH-1:0] value,
        input logic                 neg
    );
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring division step: 33-bit trial subtract plus shift.
// Ports: i_work  working register bits [63:0] ({remainder window, dividend/quotient}),
//        i_divisor divisor magnitude, o_work next 65-bit working register. Purely combinational.
module divider_step
    import divider_pkg::*;
(
    input  logic [63:0]          i_work,
    input  logic [DIV_WIDTH-1:0] i_divisor,
    output logic [64:0]          o_work
);

    logic [DIV_WIDTH:0] w_diff;

    // The extra top bit of the subtract acts as the borrow: set means the
    // divisor did not fit into the current remainder window.
    assign w_diff = {1'b0, i_work[63:32]} - {1'b0, i_divisor};

    always_comb begin
        if (w_diff[DIV_WIDTH]) begin
            o_work = {i_work, 1'b0};
        end else begin
            o_work = {w_diff[31:0], i_work[31:0], 1'b1};
        end
    end

endmodule

// File: rtl/divider.sv
// Multi-cycle 32-bit DIV/DIVU unit for the execute stage: one quotient bit per clock.
// Ports: clock/reset (sync, active-high), signed_div, operand_a, operand_b, start
//        (level-held until ready), annul (abort in flight), result {rem, quot}, ready.
module divider
    import divider_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 signed_div,
    input  logic [DIV_WIDTH-1:0] operand_a,
    input  logic [DIV_WIDTH-1:0] operand_b,
    input  logic                 start,
    input  logic                 annul,
    output logic [63:0]          result,
    output logic                 ready
);

    div_state_e           r_state;
    logic [5:0]           r_cnt;
    logic [64:0]          r_work;
    logic [DIV_WIDTH-1:0] r_divisor;
    logic                 r_signed;
    logic                 r_neg_a;
    logic                 r_neg_b;

    logic [DIV_WIDTH-1:0] w_abs_a;
    logic [DIV_WIDTH-1:0] w_abs_b;
    logic [64:0]          w_work_next;
    logic [DIV_WIDTH-1:0] w_quot_fix;
    logic [DIV_WIDTH-1:0] w_rem_fix;

    // Magnitudes of the operands as seen at capture time.
    assign w_abs_a = cond_negate(operand_a, signed_div & operand_a[31]);
    assign w_abs_b = cond_negate(operand_b, signed_div & operand_b[31]);

    divider_step u_step (
        .i_work    (r_work[63:0]),
        .i_divisor (r_divisor),
        .o_work    (w_work_next)
    );

    // Quotient is negative when the operand signs differ; the remainder takes
    // the sign of the dividend. 0x80000000 / -1 wraps back to 0x80000000.
    assign w_quot_fix = cond_negate(r_work[31:0],  r_signed & (r_neg_a ^ r_neg_b));
    assign w_rem_fix  = cond_negate(r_work[64:33], r_signed & r_neg_a);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= DIV_FREE;
            r_cnt     <= 6'd0;
            r_work    <= 65'd0;
            r_divisor <= '0;
            r_signed  <= 1'b0;
            r_neg_a   <= 1'b0;
            r_neg_b   <= 1'b0;
            result    <= 64'd0;
            ready     <= 1'b0;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    if (start && !annul) begin
                        if (operand_b == '0) begin
                            r_state <= DIV_BY_ZERO;
                        end else begin
                            r_state   <= DIV_ON;
                            r_signed  <= signed_div;
                            r_neg_a   <= operand_a[31];
                            r_neg_b   <= operand_b[31];
                            r_divisor <= w_abs_b;
                            // Pre-shifted by one so the first trial subtract
                            // already sees the dividend MSB in its window.
                            r_work    <= {32'd0, w_abs_a, 1'b0};
                            r_cnt     <= 6'd0;
                        end
                    end
                end

                DIV_BY_ZERO: begin
                    r_state <= DIV_END;
                    result  <= 64'd0;
                    ready   <= 1'b1;
                end

                DIV_ON: begin
                    if (annul) begin
                        r_state <= DIV_FREE;
                    end else if (r_cnt == DIV_ITERS) begin
                        result  <= {w_rem_fix, w_quot_fix};
                        ready   <= 1'b1;
                        r_state <= DIV_END;
                    end else begin
                        r_work <= w_work_next;
                        r_cnt  <= r_cnt + 6'd1;
                    end
                end

                DIV_END: begin
                    // Hold the result until the execute stage drops start, so a
                    // stalled pipeline never sees a second result for one request.
                    if (!start) begin
                        ready   <= 1'b0;
                        r_state <= DIV_FREE;
                    end
                end

                default: begin
                    r_state <= DIV_FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the divider: directed vectors, scoreboard queue, separate monitor.
// Stimulus pushes {expected result, expected first-ready cycle}; the monitor pops on each ready rise.
// Also covers annul, reset mid-division, held start and divide by zero.
module tb_divider;

    logic        clock;
    logic        reset;
    logic        signed_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc;
    int   checks;
    int   failures;
    logic prev_rdy;

    divider dut (
        .clock      (clock),
        .reset      (reset),
        .signed_div (signed_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    // Monitor: pops one expectation per ready rise, checks stability while held.
    initial begin
        prev_rdy = 1'b0;
        cur.res  = 64'd0;
        cur.cyc  = 0;
    end

    always @(negedge clock) begin
        if (reset) begin
            prev_rdy = 1'b0;
        end else begin
            if (ready && !prev_rdy) begin
                checks = checks + 1;
                if (sb.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL unexpected_ready cyc=%0d result=%h", cyc, result);
                end else begin
                    cur = sb.pop_front();
                    checks = checks + 1;
                    if (result !== cur.res) begin
                        failures = failures + 1;
                        $display("FAIL result cyc=%0d got=%h exp=%h", cyc, result, cur.res);
                    end
                    checks = checks + 1;
                    if (cyc != cur.cyc) begin
                        failures = failures + 1;
                        $display("FAIL latency got_cyc=%0d exp_cyc=%0d", cyc, cur.cyc);
                    end
                end
            end else if (ready) begin
                checks = checks + 1;
                if (result !== cur.res) begin
                    failures = failures + 1;
                    $display("FAIL result_stable cyc=%0d got=%h exp=%h", cyc, result, cur.res);
                end
            end
            prev_rdy = ready;
        end
    end

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Issue one division, scramble operands after capture, wait for ready,
    // hold start for 'hold' extra cycles, then release and check ready drops.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input int lat, input int hold);
        exp_t e;
        int   n;
        @(posedge clock); #1;
        signed_div = sgn;
        operand_a  = a;
        operand_b  = b;
        start      = 1'b1;
        e.res = exp_res;
        e.cyc = cyc + lat;
        sb.push_back(e);
        @(posedge clock); #1;
        operand_a  = $urandom;
        operand_b  = $urandom;
        signed_div = 1'($urandom_range(0, 1));
        n = 0;
        while (!ready && n < 60) begin
            @(posedge clock); #1;
            n++;
        end
        checks = checks + 1;
        if (!ready) begin
            failures = failures + 1;
            $display("FAIL ready_timeout a=%h b=%h waited=%0d", a, b, n);
        end
        repeat (hold) begin
            @(posedge clock); #1;
        end
        start = 1'b0;
        @(posedge clock); #1;
        check_val("ready_drop", {63'd0, ready}, 64'd0);
        check_val("result_hold", result, exp_res);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        signed_div = 1'b0;
        operand_a  = 32'd0;
        operand_b  = 32'd0;
        start      = 1'b0;
        annul      = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check_val("reset_ready", {63'd0, ready}, 64'd0);
        check_val("reset_result", result, 64'd0);
        reset = 1'b0;

        // Basic unsigned / signed vectors.
        do_div(1'b0, 32'd7,        32'd2,        {32'h1,        32'h3},        34, 0);
        do_div(1'b1, 32'hFFFFFFF9, 32'h2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 0);
        do_div(1'b1, 32'd7,        32'hFFFFFFFE, {32'h1,        32'hFFFFFFFD}, 34, 0);
        // Divide by zero, both modes.
        do_div(1'b0, 32'd5,        32'd0,        64'd0,                        2,  0);
        do_div(1'b1, 32'hFFFFFFFB, 32'd0,        64'd0,                        2,  0);
        // Unsigned boundaries.
        do_div(1'b0, 32'hFFFFFFFF, 32'd1,        {32'h0,        32'hFFFFFFFF}, 34, 0);
        do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0},        34, 0);
        do_div(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'h0,        32'h1},        34, 0);

        // Annul at iteration 10: FREE next cycle, no ready.
        @(posedge clock); #1;
        signed_div = 1'b0;
        operand_a  = 32'd100;
        operand_b  = 32'd7;
        start      = 1'b1;
        repeat (11) begin
            @(posedge clock); #1;
        end
        annul = 1'b1;
        start = 1'b0;
        @(posedge clock); #1;
        annul = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
        end
        check_val("annul_no_ready", {63'd0, ready}, 64'd0);
        do_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, 0);

        // Held start: ready/result stable for 5 extra cycles, then a fresh request.
        do_div(1'b0, 32'd1000,       32'd33, {32'hA,        32'h1E},       34, 5);
        do_div(1'b1, 32'hFFFFFF9C,   32'd7,  {32'hFFFFFFFE, 32'hFFFFFFF2}, 34, 0);

        // Reset mid-division.
        @(posedge clock); #1;
        signed_div = 1'b0;
        operand_a  = 32'd1000;
        operand_b  = 32'd33;
        start      = 1'b1;
        repeat (15) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        start = 1'b0;
        @(posedge clock); #1;
        check_val("midon_reset_ready", {63'd0, ready}, 64'd0);
        check_val("midon_reset_result", result, 64'd0);
        reset = 1'b0;
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34, 0);

        repeat (5) @(posedge clock);
        #1;
        checks = checks + 1;
        if (sb.size() != 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_pending left=%0d exp=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
